// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receive engine. The serial line is synchronised, timed
//   with a free-running bit-period counter, and each bit is decided by a
//   3-sample majority vote around mid-period. Completed frames are handed to
//   the consumer over a valid/ready handshake, together with per-frame
//   parity and framing error flags.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit period (>= 8)
//   DATA_BITS     data bits per frame, 5..9, LSB first
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   rx_i          serial line, asynchronous to clk_i, idle high
//   ready_i       consumer accepts the held frame when high with valid_o
//   data_o        received word, bit 0 = first data bit
//   valid_o       frame available
//   parity_err_o  parity mismatch for the held frame
//   frame_err_o   a stop bit was sampled 0 for the held frame
//   overrun_o     sticky: a completed frame was dropped while valid_o was high
//   busy_o        receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HM1   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_HALF  = TW'(HALF);
  localparam logic [TW-1:0] T_HP1   = TW'(HALF + 1);
  localparam logic [TW-1:0] T_ZERO  = TW'(0);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
  localparam logic          ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_DELIVER = 3'd5
  } state_e;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // XOR of all data bits (1 when the word holds an odd number of ones).
  function automatic logic xor_all(input logic [DATA_BITS-1:0] v);
    return ^v;
  endfunction

  logic                 rx_meta_q, rx_sync_q;
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_cand_q, perr_cand_d;
  logic                 ferr_cand_q, ferr_cand_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic rx_s;
  logic at_dec_s;
  logic wrap_s;
  logic dec_s;
  logic [TW-1:0] timer_inc_s;

  assign rx_s        = rx_sync_q;
  assign at_dec_s    = (timer_q == T_HP1);
  assign wrap_s      = (timer_q == T_LAST);
  assign timer_inc_s = wrap_s ? T_ZERO : (timer_q + T_ONE);
  // Third vote is the live synchronised line at HALF+1.
  assign dec_s       = maj3(samp_q[0], samp_q[1], rx_s);

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    perr_cand_d = perr_cand_q;
    ferr_cand_d = ferr_cand_q;
    armed_d     = armed_q;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    // First two votes are captured at HALF-1 and HALF.
    if (timer_q == T_HM1) begin
      samp_d[0] = rx_s;
    end else if (timer_q == T_HALF) begin
      samp_d[1] = rx_s;
    end else begin
      samp_d = samp_q;
    end

    // Consumer handshake; DELIVER below may override.
    if (valid_q && ready_i) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      valid_d   = valid_q;
      overrun_d = overrun_q;
    end

    case (state_q)
      S_IDLE: begin
        timer_d = T_ZERO;
        // Re-arm only after the line has been seen high, so a held-low
        // line (break) produces a single frame.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // This cycle is T0 (timer 0); the next cycle sees timer 1.
          state_d     = S_START;
          timer_d     = T_ONE;
          armed_d     = 1'b0;
          bit_cnt_d   = 4'd0;
          stop_cnt_d  = 1'b0;
          perr_cand_d = 1'b0;
          ferr_cand_d = 1'b0;
        end else begin
          armed_d = armed_q;
        end
      end
      S_START: begin
        timer_d = timer_inc_s;
        if (at_dec_s && dec_s) begin
          // False start: the line was high at mid-bit.
          state_d = S_IDLE;
          timer_d = T_ZERO;
        end else if (wrap_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        timer_d = timer_inc_s;
        if (at_dec_s) begin
          shift_d = {dec_s, shift_q[DATA_BITS-1:1]};
        end else begin
          shift_d = shift_q;
        end
        if (wrap_s) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = HAS_PAR ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      S_PARITY: begin
        timer_d = timer_inc_s;
        if (at_dec_s) begin
          perr_cand_d = ((xor_all(shift_q) ^ dec_s) != ODD_PAR);
        end else begin
          perr_cand_d = perr_cand_q;
        end
        if (wrap_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        timer_d = timer_inc_s;
        if (at_dec_s) begin
          if (!dec_s) begin
            ferr_cand_d = 1'b1;
          end else begin
            ferr_cand_d = ferr_cand_q;
          end
          // Leave straight after the last stop decision so the next start
          // edge is never missed.
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_DELIVER;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          stop_cnt_d = stop_cnt_q;
        end
      end
      S_DELIVER: begin
        timer_d = T_ZERO;
        state_d = S_IDLE;
        if (!valid_q || ready_i) begin
          data_d  = shift_q;
          perr_d  = perr_cand_q;
          ferr_d  = ferr_cand_q;
          valid_d = 1'b1;
        end else begin
          // Consumer still holds the previous frame: drop the new one.
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = T_ZERO;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= T_ZERO;
      bit_cnt_q   <= 4'd0;
      stop_cnt_q  <= 1'b0;
      samp_q      <= 2'b00;
      shift_q     <= '0;
      perr_cand_q <= 1'b0;
      ferr_cand_q <= 1'b0;
      armed_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      perr_cand_q <= perr_cand_d;
      ferr_cand_q <= ferr_cand_d;
      armed_q     <= armed_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
//   Five receivers at 16 clocks/bit with different frame formats share one
//   clock and reset. Frames are built bit by bit from the word, the chosen
//   parity/stop errors and the frame format; the expected word, flags and
//   valid-rise cycle are derived from the same description.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;
  localparam int CPB  = 16;
  localparam int NDUT = 5;
  localparam int DB_A  [NDUT] = '{8, 8, 8, 8, 5};
  localparam int PAR_A [NDUT] = '{0, 1, 2, 0, 2};
  localparam int SB_A  [NDUT] = '{1, 1, 1, 2, 2};

  logic clk = 1'b0;
  logic rst_n;
  logic [NDUT-1:0] rx;
  logic [NDUT-1:0] rdy;
  wire  [NDUT-1:0] vld, pe, fe, ov, bz;
  wire  [8:0] dat_w [NDUT];

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  int rise_cyc [NDUT];
  int nrise [NDUT];
  logic [NDUT-1:0] vprev = '0;

  logic [8:0] exp_data;
  logic exp_pe, exp_fe;
  int exp_rise;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wire [DB_A[g]-1:0] d_w;
    uart_rx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS(DB_A[g]),
      .PARITY(PAR_A[g]),
      .STOP_BITS(SB_A[g])
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .rx_i(rx[g]),
      .ready_i(rdy[g]),
      .data_o(d_w),
      .valid_o(vld[g]),
      .parity_err_o(pe[g]),
      .frame_err_o(fe[g]),
      .overrun_o(ov[g]),
      .busy_o(bz[g])
    );
    assign dat_w[g] = 9'(d_w);
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle in which each valid rises and count delivered frames.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (vld[i] && !vprev[i]) begin
        rise_cyc[i] <= cyc;
        nrise[i]    <= nrise[i] + 1;
      end
    end
    vprev <= vld;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v)
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Serialise one frame onto rx[idx] and compute what the receiver must report.
  task automatic send_frame(input int idx, input logic [8:0] word, input bit bad_par,
                            input bit bad_stop, input bit pulse, input int abort_off);
    bit   bits[$];
    int   k, n0, ones;
    logic [8:0] w;
    logic pb;
    w = word & ((9'h001 << DB_A[idx]) - 9'h001);
    bits.push_back(1'b0);
    for (int i = 0; i < DB_A[idx]; i++) bits.push_back(w[i]);
    exp_pe = 1'b0;
    if (PAR_A[idx] != 0) begin
      ones = $countones(w);
      pb = (PAR_A[idx] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      if (bad_par) pb = ~pb;
      bits.push_back(pb);
      ones = ones + (pb ? 1 : 0);
      exp_pe = (PAR_A[idx] == 1) ? ((ones % 2) != 0) : ((ones % 2) == 0);
    end
    for (int s = 0; s < SB_A[idx]; s++) bits.push_back(!(bad_stop && s == 0));
    exp_fe   = bad_stop;
    exp_data = w;
    k = bits.size() - 1;
    repeat (2) @(negedge clk);
    n0 = cyc;
    // 2 sync clocks, last decision at HALF+1, DELIVER, then valid registered.
    exp_rise = n0 + 2 + k * CPB + CPB / 2 + 3;
    for (int off = 0; off < (k + 1) * CPB; off++) begin
      if (abort_off >= 0 && off == abort_off) begin
        rst_n = 1'b0;
        break;
      end
      rx[idx] = bits[off / CPB];
      if (pulse && off == k * CPB + CPB / 2 + 4) rdy[idx] = 1'b1;
      else if (pulse && off == k * CPB + CPB / 2 + 5) rdy[idx] = 1'b0;
      @(negedge clk);
    end
    rx[idx] = 1'b1;
  endtask

  task automatic check_frame(input int idx, input string name);
    @(negedge clk);
    chk({name, "_valid"}, 32'(vld[idx]), 32'd1);
    chk({name, "_data"}, 32'(dat_w[idx]), 32'(exp_data));
    chk({name, "_perr"}, 32'(pe[idx]), 32'(exp_pe));
    chk({name, "_ferr"}, 32'(fe[idx]), 32'(exp_fe));
    chk({name, "_rise"}, rise_cyc[idx], exp_rise);
    chk({name, "_busy"}, 32'(bz[idx]), 32'd0);
  endtask

  task automatic accept(input int idx, input string name);
    @(negedge clk);
    rdy[idx] = 1'b1;
    @(negedge clk);
    rdy[idx] = 1'b0;
    chk({name, "_acc_valid"}, 32'(vld[idx]), 32'd0);
    chk({name, "_acc_ovr"}, 32'(ov[idx]), 32'd0);
  endtask

  initial begin
    int n, n0;
    logic [8:0] word;
    bit bp, bs;
    rst_n = 1'b0;
    rx    = '1;
    rdy   = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst%0d_valid", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst%0d_data", i), 32'(dat_w[i]), 32'd0);
      chk($sformatf("rst%0d_flags", i), {28'd0, pe[i], fe[i], ov[i], bz[i]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, -1);
    check_frame(0, "a5");
    chk("a5_ovr", 32'(ov[0]), 32'd0);
    accept(0, "a5");

    // Parity even then odd, good and bad parity bit
    send_frame(1, 9'h003, 1'b0, 1'b0, 1'b0, -1); check_frame(1, "even_ok");  accept(1, "even_ok");
    send_frame(1, 9'h003, 1'b1, 1'b0, 1'b0, -1); check_frame(1, "even_bad"); accept(1, "even_bad");
    send_frame(2, 9'h003, 1'b0, 1'b0, 1'b0, -1); check_frame(2, "odd_ok");   accept(2, "odd_ok");
    send_frame(2, 9'h003, 1'b1, 1'b0, 1'b0, -1); check_frame(2, "odd_bad");  accept(2, "odd_bad");

    // Glitch: 5 clocks low is a false start
    n = nrise[0];
    @(negedge clk);
    rx[0] = 1'b0;
    for (int off = 1; off <= 12; off++) begin
      @(negedge clk);
      if (off == 5) rx[0] = 1'b1;
      if (off == 2)  chk("glitch_busy_t0", 32'(bz[0]), 32'd0);
      if (off == 3)  chk("glitch_busy_t1", 32'(bz[0]), 32'd1);
      if (off == 11) chk("glitch_busy_dec", 32'(bz[0]), 32'd1);
      if (off == 12) chk("glitch_busy_after", 32'(bz[0]), 32'd0);
    end
    repeat (40) @(negedge clk);
    chk("glitch_no_frame", nrise[0], n);
    send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0, -1); check_frame(0, "post_glitch"); accept(0, "post_glitch");

    // Break: line low for 20 bit times gives exactly one frame
    n = nrise[0];
    @(negedge clk);
    n0 = cyc;
    rx[0] = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_count", nrise[0], n + 1);
    chk("break_data", 32'(dat_w[0]), 32'd0);
    chk("break_ferr", 32'(fe[0]), 32'd1);
    chk("break_rise", rise_cyc[0], n0 + 2 + 9 * CPB + CPB / 2 + 3);
    accept(0, "break");
    send_frame(0, 9'h07E, 1'b0, 1'b0, 1'b0, -1); check_frame(0, "post_break"); accept(0, "post_break");

    // Overrun
    send_frame(0, 9'h011, 1'b0, 1'b0, 1'b0, -1); check_frame(0, "ovr_first");
    n = nrise[0];
    send_frame(0, 9'h022, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("ovr_data_kept", 32'(dat_w[0]), 32'h11);
    chk("ovr_flag", 32'(ov[0]), 32'd1);
    chk("ovr_valid", 32'(vld[0]), 32'd1);
    chk("ovr_no_new_rise", nrise[0], n);
    accept(0, "ovr_clear");
    send_frame(0, 9'h033, 1'b0, 1'b0, 1'b0, -1); check_frame(0, "ovr_third");
    send_frame(0, 9'h044, 1'b0, 1'b0, 1'b1, -1);
    @(negedge clk);
    chk("deliver_ready_valid", 32'(vld[0]), 32'd1);
    chk("deliver_ready_data", 32'(dat_w[0]), 32'h44);
    chk("deliver_ready_ovr", 32'(ov[0]), 32'd0);
    accept(0, "deliver_ready");

    // Two stop bits, then back-to-back frames with ready tied high
    send_frame(3, 9'h05A, 1'b0, 1'b0, 1'b0, -1); check_frame(3, "stop2_5a"); accept(3, "stop2_5a");
    rdy[3] = 1'b1;
    n = nrise[3];
    send_frame(3, 9'h012, 1'b0, 1'b0, 1'b0, -1);
    send_frame(3, 9'h034, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("b2b_count", nrise[3], n + 2);
    chk("b2b_ovr", 32'(ov[3]), 32'd0);
    chk("b2b_data", 32'(dat_w[3]), 32'h34);
    chk("b2b_valid", 32'(vld[3]), 32'd0);
    rdy[3] = 1'b0;

    // Reset during data bit 3 of a frame, with another receiver holding a frame
    send_frame(1, 9'h055, 1'b0, 1'b0, 1'b0, -1); check_frame(1, "held_b");
    send_frame(0, 9'h05A, 1'b0, 1'b0, 1'b0, 4 * CPB + CPB / 2);
    #1;
    chk("arst_valid_b", 32'(vld[1]), 32'd0);
    chk("arst_data_b", 32'(dat_w[1]), 32'd0);
    chk("arst_busy_a", 32'(bz[0]), 32'd0);
    chk("arst_flags_a", {28'd0, pe[0], fe[0], ov[0], vld[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = nrise[0];
    repeat (12 * CPB) @(negedge clk);
    chk("arst_no_frame", nrise[0], n);
    chk("arst_no_valid", 32'(vld[0]), 32'd0);
    send_frame(3, 9'h05A, 1'b0, 1'b0, 1'b0, -1); check_frame(3, "rst_then_8b"); accept(3, "rst_then_8b");
    send_frame(4, 9'h05A, 1'b0, 1'b0, 1'b0, -1); check_frame(4, "rst_then_5b");
    chk("five_bit_1a", 32'(dat_w[4]), 32'h1A);
    accept(4, "rst_then_5b");

    // Randomised frames on every format
    for (int i = 0; i < NDUT; i++) begin
      for (int j = 0; j < 4; j++) begin
        word = 9'($urandom);
        bp = (PAR_A[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bs = ($urandom_range(0, 3) == 0);
        send_frame(i, word, bp, bs, 1'b0, -1);
        check_frame(i, $sformatf("rnd%0d_%0d", i, j));
        accept(i, $sformatf("rnd%0d_%0d", i, j));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
